// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: datapath width, ALU opcodes and
// the arbiter FSM state encoding.
package alu_arbiter_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int NUM_REQ     = 2;

  // ALU opcodes driven on reqN_alu_ctrl; any other code yields a result of 0.
  localparam logic [3:0] ALU_AND      = 4'b0000;
  localparam logic [3:0] ALU_OR       = 4'b0001;
  localparam logic [3:0] ALU_ADD      = 4'b0010;
  localparam logic [3:0] ALU_XOR      = 4'b0011;
  localparam logic [3:0] ALU_SLL      = 4'b0100;
  localparam logic [3:0] ALU_SRL      = 4'b0101;
  localparam logic [3:0] ALU_SUBTRACT = 4'b0110;
  localparam logic [3:0] ALU_SLT      = 4'b0111;
  localparam logic [3:0] ALU_SRA      = 4'b1000;
  localparam logic [3:0] ALU_SLTU     = 4'b1001;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational shared ALU. Shift amounts use the low log2(DATA_WIDTH) bits
// of operand B; unsupported opcodes return 0 (and therefore zero = 1).
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = INSTR_WIDTH
) (
  input  logic [3:0]            i_alu_ctrl,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  output logic [DATA_WIDTH-1:0] o_results,
  output logic                  o_zero
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_src_b[SHW-1:0];

  // Opcode decode into the result word.
  always_comb begin
    o_results = '0;
    case (i_alu_ctrl)
      ALU_AND:      o_results = i_src_a & i_src_b;
      ALU_OR:       o_results = i_src_a | i_src_b;
      ALU_ADD:      o_results = i_src_a + i_src_b;
      ALU_XOR:      o_results = i_src_a ^ i_src_b;
      ALU_SLL:      o_results = i_src_a << w_shamt;
      ALU_SRL:      o_results = i_src_a >> w_shamt;
      ALU_SUBTRACT: o_results = i_src_a - i_src_b;
      ALU_SLT:      o_results = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_src_a) < $signed(i_src_b))};
      ALU_SRA:      o_results = $signed(i_src_a) >>> w_shamt;
      ALU_SLTU:     o_results = {{(DATA_WIDTH-1){1'b0}}, (i_src_a < i_src_b)};
      default:      o_results = '0;
    endcase
  end

  assign o_zero = (o_results == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter that sequences one operation at a time
// through a shared ALU: IDLE accepts, EXEC computes from latched operands,
// RESP holds the registered result until the owner consumes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = INSTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_alu_ctrl,
  input  logic                  req0_alu_src,
  input  logic [DATA_WIDTH-1:0] req0_src1,
  input  logic [DATA_WIDTH-1:0] req0_src2,
  input  logic [DATA_WIDTH-1:0] req0_sign_ext,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_alu_ctrl,
  input  logic                  req1_alu_src,
  input  logic [DATA_WIDTH-1:0] req1_src1,
  input  logic [DATA_WIDTH-1:0] req1_src2,
  input  logic [DATA_WIDTH-1:0] req1_sign_ext,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp_results,
  output logic                  resp_zero,
  output logic                  resp_last_bit,
  output logic                  busy
);

  arb_state_t            r_state;
  logic                  r_last_grant;
  logic                  r_owner;
  logic [3:0]            r_op_ctrl;
  logic                  r_op_alu_src;
  logic [DATA_WIDTH-1:0] r_op_src1;
  logic [DATA_WIDTH-1:0] r_op_src2;
  logic [DATA_WIDTH-1:0] r_op_sign_ext;
  logic [DATA_WIDTH-1:0] r_resp_results;
  logic                  r_resp_zero;
  logic                  r_resp_last_bit;

  logic [NUM_REQ-1:0]    w_req_valid;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic [NUM_REQ-1:0]    w_resp_ready;
  logic [NUM_REQ-1:0]    w_resp_valid;
  logic                  w_grant;
  logic                  w_arb_open;
  logic                  w_accept;
  logic                  w_owner_ready;
  logic [3:0]            w_sel_ctrl;
  logic                  w_sel_alu_src;
  logic [DATA_WIDTH-1:0] w_sel_src1;
  logic [DATA_WIDTH-1:0] w_sel_src2;
  logic [DATA_WIDTH-1:0] w_sel_sign_ext;
  logic [DATA_WIDTH-1:0] w_alu_b;
  logic [DATA_WIDTH-1:0] w_alu_results;
  logic                  w_alu_zero;

  assign w_req_valid  = {req1_valid, req0_valid};
  assign w_resp_ready = {resp1_ready, resp0_ready};

  // Round-robin pick: a lone requester wins outright, a tie goes to the
  // requester that did not win last time.
  always_comb begin
    w_grant = req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end
  end

  // Acceptance is only possible in IDLE, and never while flushing or in reset.
  assign w_arb_open = (r_state == ARB_IDLE) && !flush && !rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_ready[gi]  = w_arb_open && w_req_valid[gi] && (w_grant == 1'(gi));
      assign w_resp_valid[gi] = (r_state == ARB_RESP) && (r_owner == 1'(gi));
    end
  endgenerate

  assign w_accept      = |w_req_ready;
  assign w_owner_ready = w_resp_ready[r_owner];

  assign w_sel_ctrl     = w_grant ? req1_alu_ctrl : req0_alu_ctrl;
  assign w_sel_alu_src  = w_grant ? req1_alu_src  : req0_alu_src;
  assign w_sel_src1     = w_grant ? req1_src1     : req0_src1;
  assign w_sel_src2     = w_grant ? req1_src2     : req0_src2;
  assign w_sel_sign_ext = w_grant ? req1_sign_ext : req0_sign_ext;

  // The ALU sees only latched operands, so request-port changes after
  // acceptance cannot disturb the result.
  assign w_alu_b = r_op_alu_src ? r_op_sign_ext : r_op_src2;

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_alu_ctrl(r_op_ctrl),
    .i_src_a   (r_op_src1),
    .i_src_b   (w_alu_b),
    .o_results (w_alu_results),
    .o_zero    (w_alu_zero)
  );

  // Sequencer: accept in IDLE, capture in EXEC, hand off in RESP; flush wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ARB_IDLE;
      r_last_grant    <= 1'b1;
      r_owner         <= 1'b0;
      r_op_ctrl       <= '0;
      r_op_alu_src    <= 1'b0;
      r_op_src1       <= '0;
      r_op_src2       <= '0;
      r_op_sign_ext   <= '0;
      r_resp_results  <= '0;
      r_resp_zero     <= 1'b0;
      r_resp_last_bit <= 1'b0;
    end else if (flush) begin
      r_state <= ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_accept) begin
            r_op_ctrl     <= w_sel_ctrl;
            r_op_alu_src  <= w_sel_alu_src;
            r_op_src1     <= w_sel_src1;
            r_op_src2     <= w_sel_src2;
            r_op_sign_ext <= w_sel_sign_ext;
            r_owner       <= w_grant;
            r_last_grant  <= w_grant;
            r_state       <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          r_resp_results  <= w_alu_results;
          r_resp_zero     <= w_alu_zero;
          r_resp_last_bit <= w_alu_results[0];
          r_state         <= ARB_RESP;
        end
        ARB_RESP: begin
          if (w_owner_ready) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign req0_ready    = w_req_ready[0];
  assign req1_ready    = w_req_ready[1];
  assign resp0_valid   = w_resp_valid[0];
  assign resp1_valid   = w_resp_valid[1];
  assign resp_results  = r_resp_results;
  assign resp_zero     = r_resp_zero;
  assign resp_last_bit = r_resp_last_bit;
  assign busy          = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req0_ready, req0_alu_src;
  logic [3:0]  req0_alu_ctrl;
  logic [31:0] req0_src1, req0_src2, req0_sign_ext;
  logic        req1_valid, req1_ready, req1_alu_src;
  logic [3:0]  req1_alu_ctrl;
  logic [31:0] req1_src1, req1_src2, req1_sign_ext;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_results;
  logic        resp_zero, resp_last_bit, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_alu_ctrl(req0_alu_ctrl),
    .req0_alu_src(req0_alu_src), .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req0_sign_ext(req0_sign_ext),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_alu_ctrl(req1_alu_ctrl),
    .req1_alu_src(req1_alu_src), .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req1_sign_ext(req1_sign_ext),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_results(resp_results), .resp_zero(resp_zero),
    .resp_last_bit(resp_last_bit), .busy(busy)
  );

  typedef struct {
    int          rq;
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] se;
    logic        asrc;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[14];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int i);
    return (i == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic get_rvalid(input int i);
    return (i == 0) ? resp0_valid : resp1_valid;
  endfunction

  // Reference opcode semantics on 32-bit words.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (c)
      ALU_ADD:      return a + b;
      ALU_SUBTRACT: return a - b;
      ALU_AND:      return a & b;
      ALU_OR:       return a | b;
      ALU_XOR:      return a ^ b;
      ALU_SLL:      return a << sh;
      ALU_SRL:      return a >> sh;
      ALU_SRA:      return 32'($signed(a) >>> sh);
      ALU_SLT:      return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:     return (a < b) ? 32'd1 : 32'd0;
      default:      return 32'd0;
    endcase
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int rq, input logic v, input logic [3:0] c, input logic as,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    if (rq == 0) begin
      req0_valid = v; req0_alu_ctrl = c; req0_alu_src = as;
      req0_src1 = a; req0_src2 = b; req0_sign_ext = s;
    end else begin
      req1_valid = v; req1_alu_ctrl = c; req1_alu_src = as;
      req1_src1 = a; req1_src2 = b; req1_sign_ext = s;
    end
  endtask

  task automatic set_resp_ready(input int rq, input logic v);
    if (rq == 0) resp0_ready = v;
    else resp1_ready = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    adv();
  endtask

  // One isolated operation from IDLE; entered and left just after a rising edge.
  task automatic run_op(input int rq, input logic [3:0] c, input logic as, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] s, input logic [31:0] exp_res,
                        input logic exp_zero, input int idx);
    set_req(rq, 1'b1, c, as, a, b, s);
    set_req(1 - rq, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    @(negedge clk);
    chk1($sformatf("vec%0d accept_ready", idx), get_rdy(rq), 1'b1);
    chk1($sformatf("vec%0d other_ready", idx), get_rdy(1 - rq), 1'b0);
    adv();
    set_req(rq, 1'b0, ~c, ~as, ~a, ~b, ~s);
    @(negedge clk);
    chk1($sformatf("vec%0d exec_busy", idx), busy, 1'b1);
    chk1($sformatf("vec%0d exec_no_valid", idx), resp0_valid | resp1_valid, 1'b0);
    adv();
    @(negedge clk);
    chk1($sformatf("vec%0d resp_valid", idx), get_rvalid(rq), 1'b1);
    chk1($sformatf("vec%0d other_valid", idx), get_rvalid(1 - rq), 1'b0);
    chk32($sformatf("vec%0d results", idx), resp_results, exp_res);
    chk1($sformatf("vec%0d zero", idx), resp_zero, exp_zero);
    chk1($sformatf("vec%0d last_bit", idx), resp_last_bit, exp_res[0]);
    set_resp_ready(rq, 1'b1);
    adv();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    @(negedge clk);
    chk1($sformatf("vec%0d idle_busy", idx), busy, 1'b0);
    $display("txn vec%0d req%0d ctrl=%h result=%08h zero=%b", idx, rq, c, resp_results, resp_zero);
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r0x, r1x;
    int          m_last;

    vecs[0]  = '{0, ALU_ADD,      32'd5,        32'd7,  32'd0,        1'b0, 32'd12,       1'b0};
    vecs[1]  = '{1, ALU_SUBTRACT, 32'd9,        32'd100, 32'd9,       1'b1, 32'd0,        1'b1};
    vecs[2]  = '{0, ALU_AND,      32'h0000F0F0, 32'h0000FF00, 32'd0,  1'b0, 32'h0000F000, 1'b0};
    vecs[3]  = '{1, ALU_OR,       32'h0F,       32'hF0, 32'd0,        1'b0, 32'hFF,       1'b0};
    vecs[4]  = '{0, ALU_XOR,      32'hFFFFFFFF, 32'd1,  32'd0,        1'b0, 32'hFFFFFFFE, 1'b0};
    vecs[5]  = '{0, ALU_SLL,      32'd1,        32'd31, 32'd0,        1'b0, 32'h80000000, 1'b0};
    vecs[6]  = '{1, ALU_SRL,      32'h80000000, 32'd4,  32'd0,        1'b0, 32'h08000000, 1'b0};
    vecs[7]  = '{0, ALU_SLT,      32'hFFFFFFFF, 32'd1,  32'd0,        1'b0, 32'd1,        1'b0};
    vecs[8]  = '{0, ALU_SLTU,     32'hFFFFFFFF, 32'd1,  32'd0,        1'b0, 32'd0,        1'b1};
    vecs[9]  = '{1, 4'hF,         32'd123,      32'd456, 32'd0,       1'b0, 32'd0,        1'b1};
    vecs[10] = '{0, ALU_ADD,      32'hFFFFFFFF, 32'd1,  32'd0,        1'b0, 32'd0,        1'b1};
    vecs[11] = '{1, ALU_ADD,      32'd3,        32'd50, 32'hFFFFFFFF, 1'b1, 32'd2,        1'b0};
    vecs[12] = '{0, ALU_SRA,      32'h80000000, 32'd4,  32'd0,        1'b0, 32'hF8000000, 1'b0};
    vecs[13] = '{0, ALU_SLL,      32'd1,        32'd33, 32'd0,        1'b0, 32'd2,        1'b0};

    // Reset: outputs quiet even with both requesters valid.
    rst = 1'b1; flush = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0);
    set_req(1, 1'b1, ALU_ADD, 1'b0, 32'd2, 32'd2, 32'd0);
    #2;
    chk1("reset req0_ready", req0_ready, 1'b0);
    chk1("reset req1_ready", req1_ready, 1'b0);
    chk1("reset resp0_valid", resp0_valid, 1'b0);
    chk1("reset resp1_valid", resp1_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk32("reset results", resp_results, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    adv();

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].rq, vecs[i].ctrl, vecs[i].asrc, vecs[i].s1, vecs[i].s2, vecs[i].se,
             vecs[i].exp_res, vecs[i].exp_zero, i);
    end

    // Round-robin: both always valid, consumers always ready.
    do_reset();
    r0x = 32'h00001234 ^ 32'h000000FF;
    r1x = 32'h0000AAAA ^ 32'h00005555;
    set_req(0, 1'b1, ALU_XOR, 1'b0, 32'h00001234, 32'h000000FF, 32'd0);
    set_req(1, 1'b1, ALU_XOR, 1'b0, 32'h0000AAAA, 32'h00005555, 32'd0);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1($sformatf("rr%0d req0_ready", k), req0_ready, (k % 2) == 0);
      chk1($sformatf("rr%0d req1_ready", k), req1_ready, (k % 2) == 1);
      @(negedge clk);
      @(negedge clk);
      chk1($sformatf("rr%0d resp_valid", k), get_rvalid(k % 2), 1'b1);
      chk32($sformatf("rr%0d results", k), resp_results, ((k % 2) == 0) ? r0x : r1x);
      $display("txn rr%0d req%0d result=%08h", k, k % 2, resp_results);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    adv();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;

    // Back-pressure on req0 SRA while req1 waits.
    set_req(0, 1'b1, ALU_SRA, 1'b0, 32'h80000000, 32'd4, 32'd0);
    @(negedge clk);
    chk1("bp accept req0_ready", req0_ready, 1'b1);
    adv();
    req0_valid = 1'b0;
    set_req(1, 1'b1, ALU_ADD, 1'b0, 32'd3, 32'd4, 32'd0);
    @(negedge clk);
    chk1("bp exec req1_ready", req1_ready, 1'b0);
    adv();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1($sformatf("bp%0d resp0_valid", c), resp0_valid, 1'b1);
      chk32($sformatf("bp%0d results", c), resp_results, 32'hF8000000);
      chk1($sformatf("bp%0d req1_ready", c), req1_ready, 1'b0);
      adv();
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    chk1("bp consume req1_ready", req1_ready, 1'b0);
    chk1("bp consume resp0_valid", resp0_valid, 1'b1);
    $display("txn bp req0 result=%08h", resp_results);
    adv();
    resp0_ready = 1'b0;
    @(negedge clk);
    chk1("bp resume req1_ready", req1_ready, 1'b1);
    adv();
    req1_valid = 1'b0;
    resp1_ready = 1'b1;
    adv();
    @(negedge clk);
    chk1("bp req1 resp1_valid", resp1_valid, 1'b1);
    chk32("bp req1 results", resp_results, 32'd7);
    $display("txn bp req1 result=%08h", resp_results);
    adv();
    resp1_ready = 1'b0;
    @(negedge clk);
    chk1("bp end busy", busy, 1'b0);
    adv();

    // Flush in RESP with a simultaneous request from req1.
    set_req(0, 1'b1, ALU_ADD, 1'b0, 32'd1, 32'd2, 32'd0);
    @(negedge clk);
    chk1("fl accept req0_ready", req0_ready, 1'b1);
    adv();
    req0_valid = 1'b0;
    adv();
    @(negedge clk);
    chk1("fl resp0_valid before", resp0_valid, 1'b1);
    flush = 1'b1;
    set_req(1, 1'b1, ALU_OR, 1'b0, 32'h10, 32'h01, 32'd0);
    adv();
    @(negedge clk);
    chk1("fl resp0_valid after", resp0_valid, 1'b0);
    chk1("fl busy after", busy, 1'b0);
    chk1("fl masked req1_ready", req1_ready, 1'b0);
    adv();
    flush = 1'b0;
    @(negedge clk);
    chk1("fl later req1_ready", req1_ready, 1'b1);
    adv();
    req1_valid = 1'b0;
    resp1_ready = 1'b1;
    adv();
    @(negedge clk);
    chk1("fl req1 resp1_valid", resp1_valid, 1'b1);
    chk32("fl req1 results", resp_results, 32'h11);
    $display("txn flush req1 result=%08h", resp_results);
    adv();
    resp1_ready = 1'b0;
    @(negedge clk);
    chk1("fl end busy", busy, 1'b0);
    adv();

    // Flush in EXEC drops the operation.
    set_req(0, 1'b1, ALU_ADD, 1'b0, 32'd8, 32'd8, 32'd0);
    adv();
    req0_valid = 1'b0;
    flush = 1'b1;
    adv();
    flush = 1'b0;
    @(negedge clk);
    chk1("flx busy", busy, 1'b0);
    chk1("flx resp0_valid", resp0_valid, 1'b0);
    adv();

    // Async reset during EXEC; req0 won last so a tie would go to req1 without reset.
    set_req(0, 1'b1, ALU_ADD, 1'b0, 32'd2, 32'd2, 32'd0);
    @(negedge clk);
    chk1("ar accept req0_ready", req0_ready, 1'b1);
    adv();
    req1_valid = 1'b1;
    @(negedge clk);
    chk1("ar exec busy", busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("ar busy", busy, 1'b0);
    chk1("ar req0_ready", req0_ready, 1'b0);
    chk1("ar req1_ready", req1_ready, 1'b0);
    chk1("ar resp0_valid", resp0_valid, 1'b0);
    chk32("ar results", resp_results, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk1("ar tie req0_ready", req0_ready, 1'b1);
    chk1("ar tie req1_ready", req1_ready, 1'b0);
    adv();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    adv();
    @(negedge clk);
    chk1("ar resp0_valid", resp0_valid, 1'b1);
    chk32("ar new results", resp_results, 32'd4);
    $display("txn areset req0 result=%08h", resp_results);
    adv();
    resp0_ready = 1'b0;

    // Randomized transactions against the model.
    do_reset();
    m_last = 1;
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  vp;
      logic [3:0]  c0, c1, cw;
      logic        a0, a1, aw;
      logic [31:0] x0, y0, s0, x1, y1, s1, exp_r;
      int          win, bp;
      vp = 2'($urandom_range(1, 3));
      c0 = 4'($urandom_range(0, 15)); c1 = 4'($urandom_range(0, 15));
      a0 = 1'($urandom_range(0, 1));  a1 = 1'($urandom_range(0, 1));
      x0 = $urandom; y0 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      s0 = $urandom; x1 = $urandom; s1 = 32'($urandom_range(0, 40));
      y1 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
      if (vp == 2'b11) win = (m_last == 0) ? 1 : 0;
      else win = vp[1] ? 1 : 0;
      m_last = win;
      cw = win ? c1 : c0;
      aw = win ? a1 : a0;
      exp_r = win ? ref_alu(cw, x1, aw ? s1 : y1) : ref_alu(cw, x0, aw ? s0 : y0);
      set_req(0, vp[0], c0, a0, x0, y0, s0);
      set_req(1, vp[1], c1, a1, x1, y1, s1);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      @(negedge clk);
      chk1($sformatf("rnd%0d req0_ready", n), req0_ready, win == 0);
      chk1($sformatf("rnd%0d req1_ready", n), req1_ready, win == 1);
      adv();
      set_req(0, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
      set_req(1, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
      @(negedge clk);
      chk1($sformatf("rnd%0d exec_busy", n), busy, 1'b1);
      adv();
      bp = $urandom_range(0, 3);
      for (int b = 0; b < bp; b++) begin
        set_resp_ready(1 - win, 1'($urandom_range(0, 1)));
        @(negedge clk);
        chk1($sformatf("rnd%0d hold_valid", n), get_rvalid(win), 1'b1);
        chk32($sformatf("rnd%0d hold_results", n), resp_results, exp_r);
        adv();
      end
      set_resp_ready(win, 1'b1);
      set_resp_ready(1 - win, 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk1($sformatf("rnd%0d resp_valid", n), get_rvalid(win), 1'b1);
      chk1($sformatf("rnd%0d other_valid", n), get_rvalid(1 - win), 1'b0);
      chk32($sformatf("rnd%0d results", n), resp_results, exp_r);
      chk1($sformatf("rnd%0d zero", n), resp_zero, exp_r == 32'd0);
      chk1($sformatf("rnd%0d last_bit", n), resp_last_bit, exp_r[0]);
      chk1($sformatf("rnd%0d resp_ready_block", n), req0_ready | req1_ready, 1'b0);
      $display("txn rnd%0d req%0d ctrl=%h result=%08h", n, win, cw, resp_results);
      adv();
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk1($sformatf("rnd%0d idle_busy", n), busy, 1'b0);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the single shared `alu` datapath in rv32i_sc. It accepts operations over a valid/ready handshake from requester 0 (core execute path) and requester 1 (debug/test port), and grants them round-robin. It drives the granted operands through one `alu` instance, registers the result, and returns it to the owning requester with a valid/ready handshake. One operation is in flight at a time; a synchronous flush aborts it.

## Interface
Parameters:
- `DATA_WIDTH`, default `INSTR_WIDTH` (32): operand and result width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous abort of the in-flight operation.
- `reqN_valid` in 1 (N=0,1): requester N presents an operation.
- `reqN_ready` out 1: requester N's operation is accepted this cycle.
- `reqN_alu_ctrl` in 4: ALU opcode (`rv32i_control.vh` codes).
- `reqN_alu_src` in 1: 1 selects `reqN_sign_ext` as the second operand.
- `reqN_src1`, `reqN_src2`, `reqN_sign_ext` in DATA_WIDTH: operands.
- `respN_valid` out 1: the result for requester N is held on the response bus.
- `respN_ready` in 1: requester N consumes the response.
- `resp_results` out DATA_WIDTH: registered ALU result.
- `resp_zero` out 1: registered `zero`.
- `resp_last_bit` out 1: registered result LSB.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Encodings are 2-bit constants.
- **IDLE**
  - `grant` is computed combinationally:
    - only req0 valid: grant 0.
    - only req1 valid: grant 1.
    - both valid: grant `!last_grant`.
  - `req<grant>_ready` = 1 unless `flush`. The other ready is 0.
  - On acceptance (`valid && ready`):
    - latch opcode, alu_src and the three operands into the op registers.
    - set `owner` = grant and `last_grant` = grant.
    - next state EXEC.
- **EXEC**
  - The `alu` instance is fed only from the op registers, never from the request ports.
  - Capture `results`, `zero` and `res_last_bit` into the response registers.
  - Next state RESP.
- **RESP**
  - `resp<owner>_valid` = 1. The response registers are stable.
  - On `resp<owner>_ready`: next state IDLE. No new request is accepted in this same cycle.
  - `resp<!owner>_ready` is ignored.
- **Flush**
  - In any state, `flush` forces next state IDLE and `respN_valid` to 0 next cycle. The response is dropped.
  - `flush` also masks `reqN_ready` in IDLE.
  - Flush has priority over acceptance and over response consumption.
- **Opcodes:** unsupported opcodes are not trapped. The ALU's result of 0 is returned with `resp_zero` = 1.
- **Fixed requests:** once accepted, later changes on the request ports do not affect the result.
- **Ready:** all `reqN_ready` are 0 outside IDLE.

## Timing
- **Reset values:** state IDLE, `last_grant` = 1 (req0 wins the first tie), `owner` = 0. Op and response registers are 0. All `reqN_ready`, `respN_valid` and `busy` are 0 while `rst` is high.
- **Latency:** accept at edge N; result registered at edge N+1; `resp_valid` is high from N+1.
- **Throughput:** one operation per 3 cycles when responses are consumed immediately.
- **Back-pressure:** `resp_valid` and the response data hold indefinitely until ready.
- **Reset mid-operation:** returns to IDLE asynchronously and discards the operation.

## Structure
- Add the FSM state constants (`ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`) to `rv32i_control.vh`. Opcode macros are reused from the same file.
- Sub-module: exactly one `alu` instance, `u_alu`. There is no other sub-module.

## Test plan
- **Single request:** req0 `ADD`, src1=5, src2=7, alu_src=0, resp0_ready=1 → req0_ready at cycle 0. resp0_valid at cycle 1 with results=12, zero=0, last_bit=0. busy=0 at cycle 2.
- **Sign-extended subtract:** req1 `SUBTRACT`, src1=9, sign_ext=9, alu_src=1 → resp1_valid only, results=0, zero=1.
- **Round-robin:** both requesters continuously valid with `ALU_XOR` → grants alternate 0,1,0,1 across four operations, starting with 0 after reset.
- **Back-pressure:** req0 `ALU_SRA`, src1=0x80000000, src2=4, resp0_ready held 0 for 5 cycles → results=0xF8000000, stable throughout. req1_ready=0 throughout. Acceptance resumes only in the cycle after ready.
- **Flush in RESP, with simultaneous flush/request:**
  - `flush` asserted during RESP → resp0_valid=0 next cycle, state IDLE.
  - In the same cycle as the flush, req1_valid=1 → req1_ready=0. The op is accepted one cycle later.
- **Async reset in EXEC:** `rst` pulsed between clock edges → all outputs 0 immediately. The next tie after reset is granted to req0.
